// File: rtl/bcd_to_bin.sv
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Sequential signed 6-digit BCD to 20-bit binary converter
//            (reverse double-dabble, one iteration per clock).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [3:0]  unit,
    input  logic [3:0]  ten,
    input  logic [3:0]  hun,
    input  logic [3:0]  tho,
    input  logic [3:0]  ten_tho,
    input  logic [3:0]  hun_hun,
    input  logic        sign,
    output logic [19:0] bin_out,
    output logic        sign_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_CONV   = 1'b1;
    localparam logic [4:0] LAST_ITER = 5'd19;
    localparam logic [3:0] MAX_DIGIT = 4'd9;

    logic [0:0]  state_q,    state_d;
    logic [43:0] sreg_q,     sreg_d;
    logic [4:0]  cnt_q,      cnt_d;
    logic        inv_q,      inv_d;
    logic        sign_lat_q, sign_lat_d;
    logic [19:0] bin_out_q,  bin_out_d;
    logic        sign_out_q, sign_out_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;

    logic [43:0] sreg_step;
    logic        digits_bad;

    assign digits_bad = (unit > MAX_DIGIT) || (ten > MAX_DIGIT) || (hun > MAX_DIGIT) ||
                        (tho > MAX_DIGIT) || (ten_tho > MAX_DIGIT) || (hun_hun > MAX_DIGIT);

    // Shift right, then pull each BCD nibble that received a carried-in 8 back by 3.
    always_comb begin
        sreg_step = sreg_q >> 1;
        for (int i = 0; i < 6; i++) begin
            if (sreg_step[20 + 4*i +: 4] >= 4'd8) begin
                sreg_step[20 + 4*i +: 4] = sreg_step[20 + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        inv_d      = inv_q;
        sign_lat_d = sign_lat_q;
        bin_out_d  = bin_out_q;
        sign_out_d = sign_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d     = {hun_hun, ten_tho, tho, hun, ten, unit, 20'd0};
                    inv_d      = digits_bad;
                    sign_lat_d = sign;
                    cnt_d      = 5'd0;
                    busy_d     = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                if (inv_q) begin
                    bin_out_d  = 20'd0;
                    sign_out_d = 1'b0;
                    err_d      = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    sreg_d = sreg_step;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        bin_out_d  = sreg_step[19:0];
                        sign_out_d = sign_lat_q;
                        err_d      = 1'b0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            sreg_q     <= 44'd0;
            cnt_q      <= 5'd0;
            inv_q      <= 1'b0;
            sign_lat_q <= 1'b0;
            bin_out_q  <= 20'd0;
            sign_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            inv_q      <= inv_d;
            sign_lat_q <= sign_lat_d;
            bin_out_q  <= bin_out_d;
            sign_out_q <= sign_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bin_out  = bin_out_q;
    assign sign_out = sign_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
// ============================================================================
// Module   : tb_bcd_to_bin
// Purpose  : Self-checking bench for bcd_to_bin against a decimal reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [3:0]  unit, ten, hun, tho, ten_tho, hun_hun;
    logic        sign;
    logic [19:0] bin_out;
    logic        sign_out, busy, done, err;

    int checks   = 0;
    int failures = 0;

    bcd_to_bin dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .unit      (unit),
        .ten       (ten),
        .hun       (hun),
        .tho       (tho),
        .ten_tho   (ten_tho),
        .hun_hun   (hun_hun),
        .sign      (sign),
        .bin_out   (bin_out),
        .sign_out  (sign_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Digits packed as {hun_hun, ten_tho, tho, hun, ten, unit}, so 24'h123456 means 123456.
    function automatic int ref_value(input logic [23:0] d);
        return int'(d[23:20]) * 100000 + int'(d[19:16]) * 10000 + int'(d[15:12]) * 1000 +
               int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic bit ref_bad(input logic [23:0] d);
        bit b;
        b = 1'b0;
        for (int k = 0; k < 6; k++) if (d[4*k +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [23:0] rand_legal();
        logic [23:0] d;
        for (int k = 0; k < 6; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
        return d;
    endfunction

    task automatic set_digits(input logic [23:0] d);
        {hun_hun, ten_tho, tho, hun, ten, unit} = d;
    endtask

    // Issues one start pulse, scrambles inputs after capture, and measures latency to done.
    task automatic run_conv(input logic [23:0] d, input logic s, output int lat,
                            output int busy_cnt, output logic [19:0] b,
                            output logic so, output logic e);
        @(negedge sys_clk);
        set_digits(d);
        sign  = s;
        start = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        start = 1'b0;
        set_digits(24'($urandom));
        sign = 1'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge sys_clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        b  = bin_out;
        so = sign_out;
        e  = err;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        start = 1'b0;
        sign = 1'b0;
        set_digits(24'h0);
        #23;
        checks++;
        if ({bin_out, sign_out, busy, done, err} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs: got bin=%h sign=%b busy=%b done=%b err=%b required all zero",
                     bin_out, sign_out, busy, done, err);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic check_valid(input string name, input logic [23:0] d, input logic s);
        int lat, bc;
        logic [19:0] b;
        logic so, e;
        run_conv(d, s, lat, bc, b, so, e);
        checks++;
        if (lat !== 20) begin failures++; $display("FAIL %s_latency: got %0d required 20", name, lat); end
        checks++;
        if (b !== 20'(ref_value(d))) begin
            failures++; $display("FAIL %s_bin: got %h required %h", name, b, 20'(ref_value(d)));
        end
        checks++;
        if (so !== s || e !== 1'b0) begin
            failures++; $display("FAIL %s_sign_err: got sign=%b err=%b required sign=%b err=0", name, so, e, s);
        end
        checks++;
        if (bc !== 20) begin failures++; $display("FAIL %s_busy_cycles: got %0d required 20", name, bc); end
    endtask

    task automatic test_basic();
        check_valid("basic", 24'h123456, 1'b0);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done: got %b required 0", busy); end
        @(negedge sys_clk);
        checks++;
        if (done !== 1'b0 || bin_out !== 20'h1E240) begin
            failures++;
            $display("FAIL basic_done_width: got done=%b bin=%h required done=0 bin=1e240", done, bin_out);
        end
    endtask

    task automatic test_extremes();
        check_valid("max_neg", 24'h999999, 1'b1);
        check_valid("neg_zero", 24'h000000, 1'b1);
    endtask

    task automatic test_invalid();
        int lat, bc;
        logic [19:0] b;
        logic so, e;
        run_conv(24'h000A00, 1'b1, lat, bc, b, so, e);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL invalid_latency: got %0d required 1", lat); end
        checks++;
        if (e !== 1'b1 || b !== 20'd0 || so !== 1'b0) begin
            failures++;
            $display("FAIL invalid_outputs: got err=%b bin=%h sign=%b required err=1 bin=0 sign=0", e, b, so);
        end
        check_valid("after_invalid", 24'h000042, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n_done, first, second;
        n_done = 0; first = -1; second = -1;
        @(negedge sys_clk);
        set_digits(24'h000001);
        sign  = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    first = c;
                    checks++;
                    if (bin_out !== 20'd1 || busy !== 1'b0) begin
                        failures++;
                        $display("FAIL b2b_first: got bin=%h busy=%b required bin=1 busy=0", bin_out, busy);
                    end
                    set_digits(24'h065535);
                end else if (n_done == 2) begin
                    second = c;
                    checks++;
                    if (bin_out !== 20'hFFFF) begin
                        failures++; $display("FAIL b2b_second: got bin=%h required 0ffff", bin_out);
                    end
                    start = 1'b0;
                end
            end
        end
        checks++;
        if (n_done !== 2 || (second - first) !== 21) begin
            failures++;
            $display("FAIL b2b_spacing: got dones=%0d gap=%0d required dones=2 gap=21", n_done, second - first);
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        @(negedge sys_clk);
        set_digits(24'h500000);
        sign  = 1'b1;
        start = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        start = 1'b0;
        repeat (10) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b required 1", busy); end
        #1 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({bin_out, sign_out, busy, done, err} !== 24'd0) begin
            failures++;
            $display("FAIL rstmid_async_clear: got bin=%h sign=%b busy=%b done=%b err=%b required all zero",
                     bin_out, sign_out, busy, done, err);
        end
        nd = 0;
        repeat (3) begin
            @(negedge sys_clk);
            if (done !== 1'b0) nd++;
        end
        sys_rst_n = 1'b1;
        repeat (15) begin
            @(negedge sys_clk);
            if (done !== 1'b0) nd++;
        end
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d done cycles required 0", nd); end
        check_valid("after_reset", 24'h500000, 1'b0);
    endtask

    task automatic test_random();
        int lat, bc;
        logic [19:0] b;
        logic so, e, s;
        logic [23:0] d;
        for (int n = 0; n < 2000; n++) begin
            d = rand_legal();
            s = 1'($urandom_range(0, 1));
            run_conv(d, s, lat, bc, b, so, e);
            checks++;
            if (lat !== 20 || b !== 20'(ref_value(d)) || so !== s || e !== 1'b0) begin
                failures++;
                $display("FAIL random_legal: digits=%h got lat=%0d bin=%h sign=%b err=%b required lat=20 bin=%h sign=%b err=0",
                         d, lat, b, so, e, 20'(ref_value(d)), s);
            end
        end
        for (int n = 0; n < 50; n++) begin
            d = rand_legal();
            d[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
            s = 1'($urandom_range(0, 1));
            run_conv(d, s, lat, bc, b, so, e);
            checks++;
            if (!ref_bad(d) || lat !== 1 || b !== 20'd0 || so !== 1'b0 || e !== 1'b1) begin
                failures++;
                $display("FAIL random_invalid: digits=%h got lat=%0d bin=%h sign=%b err=%b required lat=1 bin=0 sign=0 err=1",
                         d, lat, b, so, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter: accepts six signed BCD digits and returns the equivalent 20-bit unsigned magnitude plus sign, using reverse double-dabble (shift right, correct digits). It is the inverse of the display-side binary-to-BCD stage. It sits behind keypad or UART digit entry and feeds numeric setpoints back into the voltmeter datapath. A start/busy/done handshake frames each conversion, and malformed digits are flagged rather than converted.

## Interface
- Parameters: none; digit count (6), binary width (20) and iteration count (20) are fixed.
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request, sampled only in IDLE.
- unit  in  4  BCD digit 10^0.
- ten  in  4  BCD digit 10^1.
- hun  in  4  BCD digit 10^2.
- tho  in  4  BCD digit 10^3.
- ten_tho  in  4  BCD digit 10^4.
- hun_hun  in  4  BCD digit 10^5.
- sign  in  1  sign of the entered value, 1 = negative.
- bin_out  out  20  binary magnitude, held until the next completion.
- sign_out  out  1  sign associated with bin_out.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse: bin_out, sign_out and err are updated.
- err  out  1  last request contained a digit > 9, held until the next completion.

## Operation
- FSM states are IDLE and CONV. Reset enters IDLE.
- Reset values: bin_out = 0, sign_out = 0, busy = 0, done = 0, err = 0, internal 44-bit shift register = 0, iteration counter = 0.
- IDLE with start = 1 (capture edge E0):
  - Latch all six digits and sign.
  - If any digit > 9, set the invalid flag and do not convert.
  - Otherwise load the shift register as {hun_hun, ten_tho, tho, hun, ten, unit, 20'd0}.
  - Set busy = 1, counter = 0, and move to CONV.
- CONV, valid input, one iteration per cycle:
  - Shift the 44-bit register right by 1.
  - Then, for each of the six nibbles in bits [43:20], subtract 3 if the nibble is >= 8.
  - Shift and correction are combinational within the same cycle.
  - Increment the counter.
  - On the 20th iteration, write bin_out <= result[19:0], sign_out <= latched sign, err <= 0, done <= 1, busy <= 0, and return to IDLE.
- CONV, invalid input: on the first CONV edge, write bin_out <= 0, sign_out <= 0, err <= 1, done <= 1, busy <= 0, and return to IDLE.
- Arithmetic:
  - The maximum legal input is 999999 = 0xF423F, which fits in 20 bits, so no overflow is possible.
  - -0 is passed through, so sign_out = 1 with bin_out = 0 is legal.
- start while busy = 1 is ignored and not queued.
- Inputs are required stable only at the E0 edge; later changes have no effect on the conversion in flight.

## Timing
- Valid conversion:
  - busy rises after E0 and falls after E20.
  - done is high during the cycle after E20.
  - Latency from start sample to done is 20 clocks.
- Invalid conversion: done and err are visible after E1, so latency is 1 clock.
- done is exactly one cycle wide and coincides with busy = 0.
- Back-to-back operation: start held high during the done cycle is accepted at that edge. busy stays low for exactly the done cycle, so throughput is one result per 21 clocks.
- bin_out, sign_out and err change only on done edges.
- Reset asserted mid-conversion:
  - All outputs clear immediately and asynchronously.
  - No done pulse is produced.
  - The FSM is in IDLE at the first edge after release.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Digits 1,2,3,4,5,6 (hun_hun..unit), sign = 0, start pulse: done exactly 20 clocks after the start edge, bin_out = 0x1E240 (123456), sign_out = 0, err = 0, busy high for 20 cycles.
- Digits 9,9,9,9,9,9 with sign = 1: bin_out = 0xF423F, sign_out = 1. All-zero digits with sign = 1: bin_out = 0, sign_out = 1.
- ten = 4'hA, other digits 0: done 1 clock after start, err = 1, bin_out = 0, sign_out = 0. The next valid request 000042 then yields err = 0 and bin_out = 42.
- start held high continuously with inputs changed every done cycle (e.g. 000001 then 065535): results 1 and 0xFFFF (65535), done pulses 21 clocks apart, start pulses during busy produce no extra done.
- Reset asserted at iteration 10 of a conversion of 500000: all outputs 0 immediately, no done. After release, a new request 500000 gives bin_out = 0x7A120.
- Randomized 2000 legal 6-digit values compared against a decimal reference model; every result must match and arrive exactly 20 clocks after its start.
